// File: rtl/spi_flash_pkg.sv
// Shared definitions for the short SPI flash command issuers: opcodes,
// issuer state encoding and the transfer length helper.
package spi_flash_pkg;

  localparam logic [7:0] WREN  = 8'h06;
  localparam logic [7:0] WRDI  = 8'h04;
  localparam logic [7:0] RSTEN = 8'h66;
  localparam logic [7:0] RST   = 8'h99;
  localparam logic [7:0] WRSR  = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EXEC,
    FSH
  } state_t;

  // Transfer length in lane-width units: nbytes*8 bits spread over ssize lanes.
  function automatic logic [23:0] cmd_len_bits(input logic [3:0] nbytes, input int ssize);
    return 24'((32'(nbytes) * 32'd8) / 32'(ssize));
  endfunction

endpackage

// File: rtl/spi_short_cmd_if.sv
// Command bus shared by all flash command slaves, and the request port
// into the SPI request arbiter.
interface cmd_inf #(
  parameter int NSLAVE = 1,
  parameter int WDW    = 24
);
  logic              request;
  logic [7:0]        cmd;
  logic [WDW-1:0]    wdata;
  // Each slave drives only its own bit, so these are nets.
  wire  [NSLAVE-1:0] busy;
  wire  [NSLAVE-1:0] finish;

  modport master (output request, cmd, wdata, input busy, finish);
  modport slaver (input request, cmd, wdata, output busy, finish);
endinterface

interface spi_req_inf;
  logic        request;
  logic [7:0]  req_cmd;
  logic [23:0] req_len;
  logic [23:0] req_wr_len;
  logic        busy;
  logic        wr_vld;
  logic        wr_ready;
  logic        clk_en;
  logic [7:0]  wr_data;

  modport master (
    output request, req_cmd, req_len, req_wr_len, wr_vld, wr_data,
    input  busy, wr_ready, clk_en
  );
  modport slave (
    input  request, req_cmd, req_len, req_wr_len, wr_vld, wr_data,
    output busy, wr_ready, clk_en
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// Loadable byte shift register with a remaining-byte counter; presents the
// low byte as write data and advances on each accepted beat.
module spi_byte_shifter #(
  parameter int MAXB = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic [8*MAXB-1:0] load_data,
  input  logic [3:0]        load_count,
  input  logic              run,
  input  logic              wr_ready,
  input  logic              clk_en,
  output logic              wr_vld,
  output logic [7:0]        wr_data,
  output logic [3:0]        left
);

  logic [8*MAXB-1:0] shift_reg, shift_next;
  logic [3:0]        remaining_reg;
  logic              vld_reg;
  logic              fire;

  assign fire = vld_reg & wr_ready & clk_en;

  // left is the byte count after this cycle, so wr_vld can drop on the
  // same edge that moves the final byte.
  always_comb begin
    shift_next = shift_reg;
    left       = remaining_reg;
    if (load) begin
      shift_next = load_data;
      left       = load_count;
    end else if (fire) begin
      shift_next = shift_reg >> 8;
      left       = remaining_reg - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg     <= '0;
      remaining_reg <= '0;
      vld_reg       <= 1'b0;
    end else begin
      shift_reg     <= shift_next;
      remaining_reg <= left;
      vld_reg       <= run && (left != 4'd0);
    end
  end

  assign wr_vld  = vld_reg;
  assign wr_data = shift_reg[7:0];

endmodule

// File: rtl/spi_short_cmd.sv
// Issues one short SPI flash command (opcode plus optional argument bytes)
// from a configurable table, with an arbiter grant timeout.
module spi_short_cmd
  import spi_flash_pkg::*;
#(
  parameter int              MODULE_ID = 0,
  parameter int              SSIZE     = 1,
  parameter int              NCMD      = 4,
  parameter int              CMD_BASE  = 0,
  parameter int              MAXB      = 4,
  parameter logic [8*NCMD-1:0] OPCODES = {8'h99, 8'h66, 8'h04, 8'h06},
  parameter logic [4*NCMD-1:0] NBYTES  = {4'd1, 4'd1, 4'd1, 4'd1},
  parameter int              TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       rst_n,
  cmd_inf.slaver     cmd_inf,
  spi_req_inf.master inf,
  output logic       error
);

  localparam int IW = (NCMD > 1) ? $clog2(NCMD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_reg, state_next;
  logic [8:0]        offset;
  logic              in_range;
  logic              accept;
  logic [IW-1:0]     k;
  logic [7:0]        opcode;
  logic [3:0]        nbytes_sel;
  logic [3:0]        nbytes_reg;
  logic [8*MAXB-1:0] load_data;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic              err_next;
  logic              request_reg, busy_reg, finish_reg, error_reg;
  logic              run;
  logic [3:0]        left;

  // Ids below CMD_BASE wrap to large offsets and fall out of range.
  assign offset     = {1'b0, cmd_inf.cmd} - 9'(CMD_BASE);
  assign in_range   = offset < 9'(NCMD);
  assign accept     = (state_reg == IDLE) && cmd_inf.request && in_range;
  assign k          = offset[IW-1:0];
  assign opcode     = OPCODES[8*k +: 8];
  assign nbytes_sel = NBYTES[4*k +: 4];

  generate
    if (MAXB > 1) begin : g_args
      assign load_data = {cmd_inf.wdata[8*(MAXB-1)-1:0], opcode};
    end else begin : g_opcode_only
      assign load_data = opcode;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = REQ;
          tmo_next   = '0;
        end
      end
      REQ: begin
        if (inf.busy) begin
          state_next = EXEC;
        end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
          state_next = FSH;
          err_next   = 1'b1;
        end else if (tmo_reg != '1) begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      EXEC: begin
        // Grant withdrawn with bytes still pending is an arbiter abort.
        if (!inf.busy) begin
          state_next = FSH;
          err_next   = (left != 4'd0);
        end
      end
      FSH:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tmo_reg     <= '0;
      nbytes_reg  <= '0;
      request_reg <= 1'b0;
      busy_reg    <= 1'b0;
      finish_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmo_reg     <= tmo_next;
      if (accept) nbytes_reg <= nbytes_sel;
      request_reg <= (state_next == REQ);
      busy_reg    <= (state_next == REQ) || (state_next == EXEC);
      finish_reg  <= (state_next == FSH);
      error_reg   <= (state_next == FSH) && err_next;
    end
  end

  assign run = (state_next == EXEC);

  spi_byte_shifter #(
    .MAXB (MAXB)
  ) u_shifter (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  (load_data),
    .load_count (nbytes_sel),
    .run        (run),
    .wr_ready   (inf.wr_ready),
    .clk_en     (inf.clk_en),
    .wr_vld     (inf.wr_vld),
    .wr_data    (inf.wr_data),
    .left       (left)
  );

  assign inf.request    = request_reg;
  assign inf.req_cmd    = 8'h00;
  assign inf.req_len    = cmd_len_bits(nbytes_reg, SSIZE);
  assign inf.req_wr_len = cmd_len_bits(nbytes_reg, SSIZE);

  assign cmd_inf.busy[MODULE_ID]   = busy_reg;
  assign cmd_inf.finish[MODULE_ID] = finish_reg;
  assign error                     = error_reg;

endmodule

// File: tb/tb_spi_short_cmd.sv
// Directed bench: two issuers on one command bus (A: 1-lane, 5 commands;
// B: 4-lane status-register write at id 8), each with its own request port.
module tb_spi_short_cmd;

  logic clock = 1'b0;
  logic rst_n;
  logic error_a, error_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  cmd_inf #(.NSLAVE(2), .WDW(24)) cbus ();
  spi_req_inf ra ();
  spi_req_inf rb ();

  spi_short_cmd #(
    .MODULE_ID (0), .SSIZE (1), .NCMD (5), .CMD_BASE (0), .MAXB (4),
    .OPCODES   ({8'h01, 8'h99, 8'h66, 8'h04, 8'h06}),
    .NBYTES    ({4'd3, 4'd1, 4'd1, 4'd1, 4'd1}),
    .TIMEOUT   (16)
  ) dut_a (
    .clock (clock), .rst_n (rst_n), .cmd_inf (cbus), .inf (ra), .error (error_a)
  );

  spi_short_cmd #(
    .MODULE_ID (1), .SSIZE (4), .NCMD (1), .CMD_BASE (8), .MAXB (4),
    .OPCODES   (8'h01), .NBYTES (4'd3), .TIMEOUT (16)
  ) dut_b (
    .clock (clock), .rst_n (rst_n), .cmd_inf (cbus), .inf (rb), .error (error_b)
  );

  logic [7:0] beats [8];
  int nbeats, nfin, nerr, nerr_alone, nvld, nreq, first_vld, fin_at;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] id, input logic [23:0] wd);
    cbus.request = 1'b1;
    cbus.cmd     = id;
    cbus.wdata   = wd;
    @(negedge clock);
    cbus.request = 1'b0;
  endtask

  // Arbiter/sink model: grants at grant_at, releases after the last beat,
  // or withdraws grant right after beat abort_after. Records what it saw.
  task automatic run(input int sel, input int grant_at, input bit toggle, input int abort_after);
    logic vld, fin, err, req, en, granted;
    logic [7:0] dat;
    bit stop;
    nbeats = 0; nfin = 0; nerr = 0; nerr_alone = 0; nvld = 0; nreq = 0;
    first_vld = -1; fin_at = -1; granted = 1'b0; stop = 1'b0;
    for (int cyc = 0; cyc < 60 && !stop; cyc++) begin
      en = toggle ? cyc[0] : 1'b1;
      if (cyc == grant_at) granted = 1'b1;
      if (sel == 0) begin
        vld = ra.wr_vld; dat = ra.wr_data; req = ra.request; fin = cbus.finish[0]; err = error_a;
      end else begin
        vld = rb.wr_vld; dat = rb.wr_data; req = rb.request; fin = cbus.finish[1]; err = error_b;
      end
      if (req) nreq++;
      if (fin) begin
        nfin++;
        if (err) nerr++;
        if (fin_at < 0) fin_at = cyc;
      end else if (err) begin
        nerr_alone++;
      end
      if (vld) begin
        nvld++;
        if (first_vld < 0) first_vld = cyc;
        if (en) begin
          if (nbeats < 8) beats[nbeats] = dat;
          nbeats++;
          if (nbeats == abort_after) granted = 1'b0;
        end
      end else if (granted && nbeats > 0) begin
        granted = 1'b0;
      end
      if (sel == 0) begin
        ra.busy = granted; ra.clk_en = en; ra.wr_ready = 1'b1;
      end else begin
        rb.busy = granted; rb.clk_en = en; rb.wr_ready = 1'b1;
      end
      if (fin_at >= 0 && cyc > fin_at) stop = 1'b1;
      if (!stop) @(negedge clock);
    end
    $display("txn sel=%0d beats=%0d b0=%02h b1=%02h b2=%02h fin=%0d err=%0d vld=%0d req=%0d first_vld=%0d fin_at=%0d",
             sel, nbeats, beats[0], beats[1], beats[2], nfin, nerr, nvld, nreq, first_vld, fin_at);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (ra.request !== 1'b0) begin bad++; $display("FAIL rst_req_a got=%0h want=0", ra.request); end
    total++; if (cbus.busy !== 2'b00) begin bad++; $display("FAIL rst_busy got=%0h want=0", cbus.busy); end
    total++; if (cbus.finish !== 2'b00) begin bad++; $display("FAIL rst_finish got=%0h want=0", cbus.finish); end
    total++; if ({error_a, error_b} !== 2'b00) begin bad++; $display("FAIL rst_error got=%0h want=0", {error_a, error_b}); end
    total++; if ({ra.wr_vld, rb.wr_vld} !== 2'b00) begin bad++; $display("FAIL rst_wr_vld got=%0h want=0", {ra.wr_vld, rb.wr_vld}); end
    total++; if (rb.wr_data !== 8'h00) begin bad++; $display("FAIL rst_wr_data got=%0h want=0", rb.wr_data); end
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_enable();
    issue(8'd0, 24'h0);
    total++; if (ra.request !== 1'b1) begin bad++; $display("FAIL wren_request got=%0h want=1", ra.request); end
    total++; if (cbus.busy !== 2'b01) begin bad++; $display("FAIL wren_busy got=%0h want=1", cbus.busy); end
    total++; if (ra.req_len !== 24'd8) begin bad++; $display("FAIL wren_req_len got=%0d want=8", ra.req_len); end
    total++; if (ra.req_wr_len !== 24'd8) begin bad++; $display("FAIL wren_req_wr_len got=%0d want=8", ra.req_wr_len); end
    total++; if (ra.req_cmd !== 8'h00) begin bad++; $display("FAIL wren_req_cmd got=%0h want=0", ra.req_cmd); end
    run(0, 2, 1'b0, 0);
    total++; if (nbeats !== 1) begin bad++; $display("FAIL wren_nbeats got=%0d want=1", nbeats); end
    total++; if (beats[0] !== 8'h06) begin bad++; $display("FAIL wren_beat got=%0h want=06", beats[0]); end
    total++; if (first_vld !== 3) begin bad++; $display("FAIL wren_first_vld got=%0d want=3", first_vld); end
    total++; if (fin_at !== 5) begin bad++; $display("FAIL wren_fin_at got=%0d want=5", fin_at); end
    total++; if (nfin !== 1) begin bad++; $display("FAIL wren_nfin got=%0d want=1", nfin); end
    total++; if (nerr + nerr_alone !== 0) begin bad++; $display("FAIL wren_error got=%0d want=0", nerr + nerr_alone); end
  endtask

  task automatic test_status_write();
    issue(8'd8, 24'h00A55A);
    total++; if (rb.req_len !== 24'd6) begin bad++; $display("FAIL wrsr_req_len got=%0d want=6", rb.req_len); end
    total++; if (cbus.busy !== 2'b10) begin bad++; $display("FAIL wrsr_busy got=%0h want=2", cbus.busy); end
    run(1, 1, 1'b1, 0);
    total++; if (nbeats !== 3) begin bad++; $display("FAIL wrsr_nbeats got=%0d want=3", nbeats); end
    total++; if ({beats[0], beats[1], beats[2]} !== 24'h015AA5) begin bad++; $display("FAIL wrsr_beats got=%06h want=015aa5", {beats[0], beats[1], beats[2]}); end
    total++; if (nvld !== 6) begin bad++; $display("FAIL wrsr_vld_cycles got=%0d want=6", nvld); end
    total++; if (nfin !== 1 || nerr !== 0) begin bad++; $display("FAIL wrsr_finish got=%0d/%0d want=1/0", nfin, nerr); end
  endtask

  task automatic test_timeout();
    issue(8'd1, 24'h0);
    run(0, -1, 1'b0, 0);
    total++; if (nreq !== 16) begin bad++; $display("FAIL tmo_req_cycles got=%0d want=16", nreq); end
    total++; if (nfin !== 1) begin bad++; $display("FAIL tmo_nfin got=%0d want=1", nfin); end
    total++; if (nerr !== 1 || nerr_alone !== 0) begin bad++; $display("FAIL tmo_error got=%0d/%0d want=1/0", nerr, nerr_alone); end
    total++; if (nvld !== 0) begin bad++; $display("FAIL tmo_wr_vld got=%0d want=0", nvld); end
  endtask

  task automatic test_abort();
    issue(8'd8, 24'h001234);
    run(1, 1, 1'b0, 1);
    total++; if (nbeats !== 1 || beats[0] !== 8'h01) begin bad++; $display("FAIL abort_beats got=%0d/%02h want=1/01", nbeats, beats[0]); end
    total++; if (nvld !== 1) begin bad++; $display("FAIL abort_vld_cycles got=%0d want=1", nvld); end
    total++; if (nfin !== 1 || nerr !== 1) begin bad++; $display("FAIL abort_finish got=%0d/%0d want=1/1", nfin, nerr); end
  endtask

  task automatic test_reset_mid();
    int waited;
    int fins;
    issue(8'd4, 24'h00BEEF);
    total++; if (ra.req_len !== 24'd24) begin bad++; $display("FAIL midrst_req_len got=%0d want=24", ra.req_len); end
    ra.busy = 1'b1; ra.clk_en = 1'b0; ra.wr_ready = 1'b1;
    waited = 0;
    while (!ra.wr_vld && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    total++; if (ra.wr_vld !== 1'b1) begin bad++; $display("FAIL midrst_reach_exec got=%0h want=1", ra.wr_vld); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ra.request, ra.wr_vld, error_a} !== 3'b000) begin bad++; $display("FAIL midrst_outputs got=%0h want=0", {ra.request, ra.wr_vld, error_a}); end
    total++; if ({cbus.busy[0], cbus.finish[0]} !== 2'b00) begin bad++; $display("FAIL midrst_bus got=%0h want=0", {cbus.busy[0], cbus.finish[0]}); end
    total++; if (ra.wr_data !== 8'h00 || ra.req_len !== 24'd0) begin bad++; $display("FAIL midrst_data got=%0h/%0d want=0/0", ra.wr_data, ra.req_len); end
    @(negedge clock);
    rst_n = 1'b1; ra.busy = 1'b0; ra.clk_en = 1'b1;
    fins = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (cbus.finish[0] || ra.request) fins++;
    end
    total++; if (fins !== 0) begin bad++; $display("FAIL midrst_no_finish got=%0d want=0", fins); end
    issue(8'd1, 24'h0);
    run(0, 1, 1'b0, 0);
    total++; if (nbeats !== 1 || beats[0] !== 8'h04) begin bad++; $display("FAIL wrdi_beat got=%0d/%02h want=1/04", nbeats, beats[0]); end
    total++; if (nfin !== 1 || nerr !== 0) begin bad++; $display("FAIL wrdi_finish got=%0d/%0d want=1/0", nfin, nerr); end
  endtask

  task automatic test_ignored();
    int seen;
    logic [7:0] ids [2];
    ids[0] = 8'd5; ids[1] = 8'd9;
    for (int t = 0; t < 2; t++) begin
      issue(ids[t], 24'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (cbus.busy != 2'b00 || cbus.finish != 2'b00 || ra.request || rb.request) seen++;
        @(negedge clock);
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL out_of_range id=%0d got=%0d want=0", ids[t], seen); end
    end
    issue(8'd0, 24'h0);
    @(negedge clock);
    issue(8'd2, 24'h0);
    run(0, 0, 1'b0, 0);
    total++; if (nbeats !== 1 || beats[0] !== 8'h06) begin bad++; $display("FAIL busy_req_beat got=%0d/%02h want=1/06", nbeats, beats[0]); end
    total++; if (nfin !== 1) begin bad++; $display("FAIL busy_req_nfin got=%0d want=1", nfin); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (cbus.busy[0] || ra.request) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL busy_req_queued got=%0d want=0", seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    cbus.request = 1'b0; cbus.cmd = 8'h00; cbus.wdata = 24'h0;
    ra.busy = 1'b0; ra.wr_ready = 1'b1; ra.clk_en = 1'b1;
    rb.busy = 1'b0; rb.wr_ready = 1'b1; rb.clk_en = 1'b1;
    test_reset();
    test_write_enable();
    test_status_write();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
